// File: rtl/shift_seq_arb.sv
// shift_seq_arb: two-requester round-robin arbiter feeding an LSB-first
// serialiser. The winner's word is latched in IDLE, shifted out over WIDTH
// cycles, optionally followed by an even-parity bit, then a one-cycle done
// pulse. The optional parity phase is enabled with macro SHIFT_PARITY_EN.
module shift_seq_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             Q,
    output logic             Q_valid,
    output logic             done,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SHIFT_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2
    } state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last_served;
`ifdef SHIFT_PARITY_EN
    logic             par_bit;
`endif

    logic             pick_c;
    logic [WIDTH-1:0] win_data_c;

    // Round-robin pick: a sole requester wins, on contention the one not served last
    always_comb begin
        pick_c = req[1];
        if (req == 2'b11) begin
            pick_c = ~last_served;
        end
        win_data_c = pick_c ? data1 : data0;
    end

    // Sequencer: Q always mirrors shreg[0] while shifting, all outputs registered
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            Q           <= 1'b0;
            Q_valid     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            last_served <= 1'b1;
`ifdef SHIFT_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state   <= SHIFT;
                        shreg   <= win_data_c;
                        cnt     <= '0;
                        gnt     <= pick_c ? 2'b10 : 2'b01;
                        Q       <= win_data_c[0];
                        Q_valid <= 1'b1;
                        busy    <= 1'b1;
`ifdef SHIFT_PARITY_EN
                        par_bit <= ^win_data_c;
`endif
                    end
                end
                SHIFT: begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
`ifdef SHIFT_PARITY_EN
                        state   <= PARITY;
                        Q       <= par_bit;
                        Q_valid <= 1'b1;
`else
                        state   <= DONE;
                        Q       <= 1'b0;
                        Q_valid <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        Q <= shreg[1];
                    end
                end
`ifdef SHIFT_PARITY_EN
                PARITY: begin
                    state   <= DONE;
                    Q       <= 1'b0;
                    Q_valid <= 1'b0;
                    done    <= 1'b1;
                end
`endif
                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    gnt         <= 2'b00;
                    busy        <= 1'b0;
                    last_served <= gnt[1];
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= 2'b00;
                    Q       <= 1'b0;
                    Q_valid <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_arb.sv
// Directed bench for shift_seq_arb at WIDTH=8; follows SHIFT_PARITY_EN.
module tb_shift_seq_arb;

    localparam int W = 8;
`ifdef SHIFT_PARITY_EN
    localparam int TL = W + 2;
`else
    localparam int TL = W + 1;
`endif

    logic         Clock;
    logic         Resetn;
    logic [1:0]   req;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic [1:0]   gnt;
    logic         Q;
    logic         Q_valid;
    logic         done;
    logic         busy;

    int checks;
    int failures;

    shift_seq_arb #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .req    (req),
        .data0  (data0),
        .data1  (data1),
        .gnt    (gnt),
        .Q      (Q),
        .Q_valid(Q_valid),
        .done   (done),
        .busy   (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected {busy, done, Q_valid, Q} at cycle pos of a transaction on word w
    function automatic logic [3:0] exp_out(input int pos, input logic [W-1:0] w);
        if (pos < W) return {1'b1, 1'b0, 1'b1, w[pos]};
`ifdef SHIFT_PARITY_EN
        if (pos == W) return {1'b1, 1'b0, 1'b1, ^w};
`endif
        if (pos == TL - 1) return 4'b1100;
        return 4'b0000;
    endfunction

    // Asynchronous reset with both requesting, before any clock edge
    task automatic test_reset();
        req   = 2'b11;
        data0 = 8'hFF;
        data1 = 8'hFF;
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=00", gnt);
        end
        checks++;
        if ({busy, done, Q_valid, Q} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs busy,done,qv,q got=%b exp=0000", {busy, done, Q_valid, Q});
        end
    endtask

    // Lone requester 0 with A5; first edge after reset release grants
    task automatic test_single();
        logic [3:0]   e;
        logic [1:0]   eg;
        logic [W-1:0] w;
        w = 8'hA5;
        @(negedge Clock);
        Resetn = 1'b1;
        req    = 2'b01;
        data0  = w;
        data1  = 8'h3C;
        for (int c = 0; c <= TL; c++) begin
            @(negedge Clock);
            e  = exp_out(c, w);
            eg = (c < TL) ? 2'b01 : 2'b00;
            checks++;
            if ({busy, done, Q_valid, Q} !== e) begin
                failures++;
                $display("FAIL single_out c=%0d got=%b exp=%b", c, {busy, done, Q_valid, Q}, e);
            end
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL single_gnt c=%0d got=%b exp=%b", c, gnt, eg);
            end
            if (c == 0) req = 2'b00;
        end
    endtask

    // Both held from reset: 01,10,01 with one idle cycle between transactions
    task automatic test_contention();
        logic [3:0]   e;
        logic [1:0]   eg;
        logic [W-1:0] w;
        int           txn;
        int           pos;
        @(negedge Clock);
        Resetn = 1'b0;
        req    = 2'b00;
        @(negedge Clock);
        Resetn = 1'b1;
        req    = 2'b11;
        data0  = 8'hA5;
        data1  = 8'h07;
        for (int c = 0; c < 3 * (TL + 1); c++) begin
            @(negedge Clock);
            txn = c / (TL + 1);
            pos = c % (TL + 1);
            w   = (txn % 2 == 1) ? 8'h07 : 8'hA5;
            eg  = (pos < TL) ? ((txn % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            e   = exp_out(pos, w);
            checks++;
            if ({busy, done, Q_valid, Q} !== e) begin
                failures++;
                $display("FAIL contend_out txn=%0d pos=%0d got=%b exp=%b", txn, pos, {busy, done, Q_valid, Q}, e);
            end
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL contend_gnt txn=%0d pos=%0d got=%b exp=%b", txn, pos, gnt, eg);
            end
        end
        req = 2'b00;
    endtask

    // req1 and data0 change mid-transaction: no effect until after DONE
    task automatic test_late();
        logic [3:0]   e;
        logic [1:0]   eg;
        logic [W-1:0] w;
        int           txn;
        int           pos;
        @(negedge Clock);
        Resetn = 1'b0;
        req    = 2'b00;
        @(negedge Clock);
        Resetn = 1'b1;
        req    = 2'b01;
        data0  = 8'h3C;
        data1  = 8'h5A;
        for (int c = 0; c < 2 * (TL + 1); c++) begin
            @(negedge Clock);
            txn = c / (TL + 1);
            pos = c % (TL + 1);
            w   = (txn == 1) ? 8'h5A : 8'h3C;
            eg  = (pos < TL) ? ((txn == 1) ? 2'b10 : 2'b01) : 2'b00;
            e   = exp_out(pos, w);
            checks++;
            if ({busy, done, Q_valid, Q} !== e) begin
                failures++;
                $display("FAIL late_out txn=%0d pos=%0d got=%b exp=%b", txn, pos, {busy, done, Q_valid, Q}, e);
            end
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL late_gnt txn=%0d pos=%0d got=%b exp=%b", txn, pos, gnt, eg);
            end
            if (c == 2) data0 = 8'hFF;
            if (c == 3) req = 2'b11;
            if (c == TL + 1) req = 2'b00;
        end
    endtask

    // Reset on the 4th SHIFT cycle aborts silently; requester 0 wins afterwards
    task automatic test_abort();
        logic [3:0]   e;
        logic [1:0]   eg;
        logic [W-1:0] w;
        w = 8'hA5;
        @(negedge Clock);
        Resetn = 1'b0;
        req    = 2'b00;
        @(negedge Clock);
        Resetn = 1'b1;
        req    = 2'b01;
        data0  = w;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            e = exp_out(c, w);
            checks++;
            if ({busy, done, Q_valid, Q} !== e || gnt !== 2'b01) begin
                failures++;
                $display("FAIL abort_pre c=%0d got=%b/%b exp=%b/01", c, {busy, done, Q_valid, Q}, gnt, e);
            end
        end
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, done, Q_valid, Q} !== 6'b000000) begin
            failures++;
            $display("FAIL abort_async gnt,busy,done,qv,q got=%b exp=000000", {gnt, busy, done, Q_valid, Q});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            checks++;
            if ({gnt, busy, done} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_hold c=%0d gnt,busy,done got=%b exp=0000", c, {gnt, busy, done});
            end
        end
        Resetn = 1'b1;
        req    = 2'b11;
        for (int c = 0; c <= TL; c++) begin
            @(negedge Clock);
            e  = exp_out(c, w);
            eg = (c < TL) ? 2'b01 : 2'b00;
            checks++;
            if ({busy, done, Q_valid, Q} !== e) begin
                failures++;
                $display("FAIL abort_post_out c=%0d got=%b exp=%b", c, {busy, done, Q_valid, Q}, e);
            end
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL abort_post_gnt c=%0d got=%b exp=%b", c, gnt, eg);
            end
            if (c == 0) req = 2'b00;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Resetn   = 1'b1;
        req      = 2'b00;
        data0    = '0;
        data1    = '0;
        test_reset();
        test_single();
        test_contention();
        test_late();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
